// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    WRITE,
    SETTLE,
    DRAIN
  } arb_state_e;

  // Readback value of the UART shift register once the line has gone idle.
  localparam logic [10:0] UART_IDLE_PATTERN = 11'h7FF;

  // Only the low byte lane of the data register is written.
  localparam logic [3:0]  UART_DATA_WSTRB   = 4'b0001;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and UART write-port bundle
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]   req_valid_i;
  logic [8*NREQ-1:0] req_data_i;
  logic [NREQ-1:0]   req_last_i;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ-1:0]   grant_o;
  logic              uart_enable_o;
  logic [3:0]        uart_wstrb_o;
  logic [31:0]       uart_addr_o;
  logic [31:0]       uart_wvalue_o;
  logic [31:0]       uart_rvalue_i;
  logic              busy_o;

  // Requesters plus the UART readback side.
  modport master (
    output req_valid_i, req_data_i, req_last_i, uart_rvalue_i,
    input  req_ready_o, grant_o, uart_enable_o, uart_wstrb_o,
           uart_addr_o, uart_wvalue_o, busy_o
  );

  // The arbiter itself.
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, uart_rvalue_i,
    output req_ready_o, grant_o, uart_enable_o, uart_wstrb_o,
           uart_addr_o, uart_wvalue_o, busy_o
  );

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// rtl/uart_tx_arbiter_rr.sv - combinational round-robin one-hot picker
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  grant_o
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan starting at the pointer, wrapping, and grant the first active request.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % NREQ);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter for one memory-mapped UART; UART_ARB_LOCK_EN enables message lock
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter logic [31:0] UART_ADDR = 32'h0,
  parameter int          HOLDOFF   = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  uart_tx_arbiter_if.slave bus
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  owner_q, owner_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NREQ-1:0]  arb_grant;
  logic [NREQ-1:0]  sel_grant;
  logic [PTR_W-1:0] owner_idx;
  logic             sel_valid;
  logic [7:0]       sel_data;
`ifdef UART_ARB_LOCK_EN
  logic             sel_last;
`endif

  logic [NREQ-1:0]  ready;
  logic [NREQ-1:0]  grant;
  logic             enable;
  logic [3:0]       wstrb;
  logic [31:0]      wvalue;

  // Upper readback bits are not part of the shift register; req_last_i only matters with the lock.
  logic unused_inputs;
  assign unused_inputs = ^{bus.uart_rvalue_i[31:11], bus.req_last_i};

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_rr (
    .req_i   (bus.req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant)
  );

  // While locked, IDLE offers the grant only to the message owner, valid or not.
`ifdef UART_ARB_LOCK_EN
  assign sel_grant = lock_q ? owner_q : arb_grant;
`else
  assign sel_grant = arb_grant;
`endif

  // Decode the owner's index and mux its byte for capture in ACCEPT.
  always_comb begin
    owner_idx = '0;
    sel_data  = '0;
`ifdef UART_ARB_LOCK_EN
    sel_last  = 1'b0;
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (owner_q[k]) begin
        owner_idx = PTR_W'(k);
        sel_data  = bus.req_data_i[8*k +: 8];
`ifdef UART_ARB_LOCK_EN
        sel_last  = bus.req_last_i[k];
`endif
      end
    end
  end

  assign sel_valid = |(owner_q & bus.req_valid_i);

  // State and datapath registers; reset parks in DRAIN so a byte already shifting finishes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= DRAIN;
      owner_q <= '0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    ready   = '0;
    grant   = owner_q;
    enable  = 1'b0;
    wstrb   = '0;
    wvalue  = '0;

    case (state_q)
      IDLE: begin
        grant   = sel_grant;
        owner_d = sel_grant;
        if (|(sel_grant & bus.req_valid_i)) begin
          state_d = ACCEPT;
        end
      end

      ACCEPT: begin
        ready = owner_q;
        if (sel_valid) begin
          data_d  = sel_data;
          ptr_d   = (owner_idx == PTR_W'(NREQ - 1)) ? '0 : owner_idx + PTR_W'(1);
`ifdef UART_ARB_LOCK_EN
          lock_d  = ~sel_last;
`else
          lock_d  = 1'b0;
`endif
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end

      WRITE: begin
        enable  = 1'b1;
        wstrb   = UART_DATA_WSTRB;
        wvalue  = {24'h0, data_q};
        cnt_d   = '0;
        state_d = SETTLE;
      end

      SETTLE: begin
        // The UART readback is registered, so the first cycles after a write show stale data.
        if (cnt_q == CNT_W'(HOLDOFF - 1)) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DRAIN: begin
        if (bus.uart_rvalue_i[10:0] == UART_IDLE_PATTERN) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = DRAIN;
      end
    endcase
  end

  assign bus.req_ready_o   = ready;
  assign bus.grant_o       = grant;
  assign bus.uart_enable_o = enable;
  assign bus.uart_wstrb_o  = wstrb;
  assign bus.uart_addr_o   = UART_ADDR;
  assign bus.uart_wvalue_o = wvalue;
  assign bus.busy_o        = (state_q != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single memory-mapped UART transmitter between NREQ byte-stream requesters, e.g. core console, trap logger and debug monitor. It arbitrates round-robin, issues one UART data-register write per byte, then paces the next write by polling the UART shift-register readback until the line is idle. It sits between the requesters and the UART's bus-style write port, replacing direct CPU stores to the UART.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..8)
- UART_ADDR, 32'h0: address driven on writes (data register, addr[3:2]==0)
- HOLDOFF, 2: cycles ignored after a write before polling readback (≥2, covers the UART's registered readback)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  NREQ  byte available per requester
- req_data_i  in  8*NREQ  byte for requester k at [8k+7:8k]
- req_last_i  in  NREQ  byte ends a message
- req_ready_o  out  NREQ  handshake; one-hot or zero
- grant_o  out  NREQ  current owner, one-hot or zero
- uart_enable_o  out  1  UART write strobe
- uart_wstrb_o  out  4  byte strobes, 4'b0001 when enabled
- uart_addr_o  out  32  UART_ADDR
- uart_wvalue_o  out  32  {24'b0, byte}
- uart_rvalue_i  in  32  UART readback; bits [10:0] are the shift register
- busy_o  out  1  state != IDLE

## Operation
- Handshake: byte transfers when req_valid_i[k] & req_ready_o[k]. Once valid is raised, a requester must hold valid, data and last stable until ready.
- States:
  - IDLE: select owner (lock/round-robin rules below); if owner valid -> ACCEPT.
  - ACCEPT (1 cycle): req_ready_o[owner]=1 combinationally; capture data/last -> WRITE; if owner valid low -> IDLE, nothing captured.
  - WRITE (1 cycle): uart_enable_o=1, wstrb/wvalue driven from registers -> SETTLE.
  - SETTLE: count HOLDOFF cycles -> DRAIN.
  - DRAIN: stay until uart_rvalue_i[10:0]==11'h7FF -> IDLE.
- Round-robin: search starts at (last served + 1) mod NREQ; after reset, requester 0 has highest priority. Pointer updates only on a captured byte.
- grant_o is held from IDLE selection through DRAIN; it is zero in IDLE when no owner is selected.
- Unused outputs are 0 when not in ACCEPT/WRITE.
- Reset: state=DRAIN so a byte already shifting completes before any new write; grant_o=0, req_ready_o=0, uart_enable_o=0, uart_wstrb_o=0, uart_wvalue_o=0, uart_addr_o=UART_ADDR, busy_o=1, lock cleared, pointer=0.
- Reset mid-operation: captured byte is dropped; UART is not rewritten.
- Simultaneous valid: exactly one ready per cycle; the loser waits without penalty.

## Timing
- Valid seen in IDLE -> ready next cycle (ACCEPT) -> uart_enable_o the cycle after. Issue latency is 2 cycles from IDLE with valid.
- Bytes are never closer than 11 bit periods plus 2+HOLDOFF cycles.
- Exactly one uart_enable_o pulse per accepted byte; no pulse in any other state.

## Configuration
- UART_ARB_LOCK_EN defined: message lock.
  - After accepting a byte with req_last_i=0, the owner keeps the grant. IDLE waits only for that requester, indefinitely, and others are blocked.
  - Lock releases after a byte with last=1.
- Not defined: req_last_i is ignored and arbitration runs per byte.

## Structure
- Package uart_arb_pkg:
  - state enum (IDLE, ACCEPT, WRITE, SETTLE, DRAIN)
  - UART_IDLE_PATTERN=11'h7FF
  - UART_DATA_WSTRB=4'b0001
- Sub-module rr_arbiter: NREQ request vector plus pointer in, one-hot grant out, purely combinational. Pointer and lock registers live in uart_tx_arbiter.

## Test plan
- Single request, data 8'h41, rvalue forced 11'h7FF after HOLDOFF -> one enable with wvalue 32'h41, wstrb 4'b0001; busy_o returns low.
- Both requesters always valid (0xA0.., 0xB0..), lock off -> accepted order A0,B0,A1,B1; never two ready bits high.
- Lock on; requester 0 sends 3 bytes (last on 3rd), requester 1 valid throughout -> req0's 3 bytes are contiguous, then req1 is served.
- Hold rvalue[10:0]=11'h3FE for 500 cycles -> no second enable until it reads 11'h7FF.
- Assert rst_i in SETTLE -> outputs at reset values next cycle; no enable until rvalue idle.
- Drop valid during ACCEPT -> no capture, back to IDLE, pointer unchanged.
